// File: rtl/sqlite_row_player.sv
// sqlite_row_player: replays rows from the SQLite store. Issues one row-fetch request at a time
// to the DPI bridge, assembles the returned column beats into a whole row, buffers rows in a
// small FIFO and streams them out over valid/ready. A FIFO slot is reserved before each request
// is issued, so a returning row can always be pushed.
`timescale 1ns/1ps
module sqlite_row_player #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned ROW_ID_W = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ROW_ID_W-1:0]          first_row_id,
  input  logic [ROW_ID_W-1:0]          row_count,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         col_err,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [ROW_ID_W-1:0]          req_row_id,
  input  logic                         rsp_valid,
  output logic                         rsp_ready,
  input  logic [DATA_W-1:0]            rsp_data,
  input  logic                         rsp_last,
  input  logic                         rsp_err,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_COLS*DATA_W-1:0]   out_row,
  output logic [ROW_ID_W-1:0]          out_row_id,
  output logic                         out_last
);

  localparam int unsigned RowW = NUM_COLS * DATA_W;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ColW = $clog2(NUM_COLS + 1);

  localparam logic [CntW-1:0]     DepthC   = CntW'(DEPTH);
  localparam logic [ColW-1:0]     NumColsC = ColW'(NUM_COLS);
  localparam logic [ColW-1:0]     LastColC = ColW'(NUM_COLS - 1);
  localparam logic [ROW_ID_W-1:0] OneId    = ROW_ID_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCollect,
    StDrain
  } state_e;

  state_e                state_q;
  logic                  done_q;
  logic                  err_q;
  logic                  col_err_q;
  logic [ROW_ID_W-1:0]   id_q;
  logic [ROW_ID_W-1:0]   rem_q;
  logic [ColW-1:0]       col_q;
  logic [RowW-1:0]       row_q;

  // Row FIFO storage and bookkeeping
  logic [RowW-1:0]       mem_row  [DEPTH];
  logic [ROW_ID_W-1:0]   mem_id   [DEPTH];
  logic                  mem_last [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       cnt_q;

  logic                  beat;
  logic                  push;
  logic                  pop;
  logic                  push_last;
  logic [RowW-1:0]       row_merged;

  assign beat      = (state_q == StCollect) && rsp_valid;
  assign push      = beat && !rsp_err && rsp_last;
  assign pop       = out_valid && out_ready;
  assign push_last = (rem_q == OneId);

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;
  assign col_err    = col_err_q;
  // Requesting only while a slot is free reserves room for the row in flight.
  assign req_valid  = (state_q == StReq) && (cnt_q < DepthC);
  assign req_row_id = id_q;
  assign rsp_ready  = (state_q == StCollect);
  assign out_valid  = (cnt_q != '0);
  assign out_row    = mem_row[rd_ptr_q];
  assign out_row_id = mem_id[rd_ptr_q];
  assign out_last   = mem_last[rd_ptr_q];

  // Current row with this cycle's beat written into its column; beats past the end are dropped
  always_comb begin
    row_merged = row_q;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (col_q == ColW'(c)) begin
        row_merged[c*DATA_W +: DATA_W] = rsp_data;
      end
    end
  end

  // Run control: request sequencing, beat collection, sticky error flags and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      col_err_q <= 1'b0;
      id_q      <= '0;
      rem_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (row_count == '0) begin
              done_q <= 1'b1;
            end else begin
              id_q      <= first_row_id;
              rem_q     <= row_count;
              err_q     <= 1'b0;
              col_err_q <= 1'b0;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (req_valid && req_ready) begin
            // Unfilled columns of a short row stay zero.
            col_q   <= '0;
            row_q   <= '0;
            state_q <= StCollect;
          end
        end
        StCollect: begin
          if (rsp_valid) begin
            if (rsp_err) begin
              err_q   <= 1'b1;
              state_q <= StDrain;
            end else begin
              row_q <= row_merged;
              if (col_q >= NumColsC) begin
                col_err_q <= 1'b1;
              end else begin
                col_q <= col_q + ColW'(1);
              end
              if (rsp_last) begin
                if (col_q < LastColC) begin
                  col_err_q <= 1'b1;
                end
                id_q    <= id_q + OneId;
                rem_q   <= rem_q - OneId;
                state_q <= (rem_q == OneId) ? StDrain : StReq;
              end
            end
          end
        end
        StDrain: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Row FIFO: push of a completed row and pop by the consumer may happen in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_row[i]  <= '0;
        mem_id[i]   <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_row[wr_ptr_q]  <= row_merged;
        mem_id[wr_ptr_q]   <= id_q;
        mem_last[wr_ptr_q] <= push_last;
        wr_ptr_q           <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sqlite_row_player.sv
// Bench for sqlite_row_player: a randomised bridge model serves row requests, a consumer applies
// configurable back-pressure, and each scenario compares the delivered rows, request ids and
// flags with a reference built from the beats the bridge actually sent.
`timescale 1ns/1ps
module tb_sqlite_row_player;

  localparam int MAXR = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [31:0]   first_row_id;
  logic [31:0]   row_count;
  logic          busy;
  logic          done;
  logic          err;
  logic          col_err;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_row_id;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_data;
  logic          rsp_last;
  logic          rsp_err;
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_row;
  logic [31:0]   out_row_id;
  logic          out_last;

  sqlite_row_player dut (
    .clk(clk), .rst(rst), .start(start), .first_row_id(first_row_id), .row_count(row_count),
    .busy(busy), .done(done), .err(err), .col_err(col_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_row_id(req_row_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_id(out_row_id), .out_last(out_last)
  );

  int checks = 0;
  int passed = 0;

  // Bridge plan per request index within a run
  int          plan_beats [MAXR];
  bit          plan_err   [MAXR];
  logic [63:0] beat_data  [MAXR][8];
  int          cons_mode;

  // Observations
  logic [31:0]  req_log [$];
  logic [255:0] got_row [$];
  logic [31:0]  got_id  [$];
  bit           got_last[$];
  int           done_cnt;
  int           viol;
  bit           req_hs, rsp_hs;

  // Reference
  logic [255:0] exp_row [$];
  logic [31:0]  exp_id  [$];
  bit           exp_last[$];
  logic [31:0]  exp_req [$];
  bit           exp_err, exp_col;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Monitor: samples at negedge, away from the active edge
  initial begin
    bit           prev_out_stall, prev_req_stall;
    logic [255:0] prev_row;
    logic [31:0]  prev_oid, prev_rid;
    bit           prev_olast;
    prev_out_stall = 0; prev_req_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_out_stall = 0; prev_req_stall = 0; req_hs = 0; rsp_hs = 0;
      end else begin
        req_hs = req_valid && req_ready;
        rsp_hs = rsp_valid && rsp_ready;
        if (req_hs) req_log.push_back(req_row_id);
        if (out_valid && out_ready) begin
          got_row.push_back(out_row); got_id.push_back(out_row_id); got_last.push_back(out_last);
        end
        if (prev_out_stall && (!out_valid || out_row !== prev_row || out_row_id !== prev_oid ||
                               out_last !== prev_olast)) viol++;
        if (prev_req_stall && (!req_valid || req_row_id !== prev_rid)) viol++;
        if (done) begin
          done_cnt++;
          if (busy || out_valid) viol++;
        end
        prev_out_stall = out_valid && !out_ready;
        prev_row = out_row; prev_oid = out_row_id; prev_olast = out_last;
        prev_req_stall = req_valid && !req_ready;
        prev_rid = req_row_id;
      end
    end
  end

  // Consumer
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (cons_mode)
        0:       out_ready = 0;
        1:       out_ready = 1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Bridge model: one request at a time, random gaps, beats per the plan
  initial begin
    int br_phase, br_idx, br_beat, br_n;
    br_phase = 0; br_idx = 0; br_beat = 0; br_n = 0;
    req_ready = 0; rsp_valid = 0; rsp_last = 0; rsp_err = 0; rsp_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        br_phase = 0; req_ready = 0; rsp_valid = 0; rsp_last = 0; rsp_err = 0;
        continue;
      end
      if (br_phase == 0) begin
        if (req_hs) begin
          br_idx = req_log.size() - 1;
          br_n = plan_err[br_idx] ? 1 : plan_beats[br_idx];
          for (int b = 0; b < br_n; b++) beat_data[br_idx][b] = {$urandom, $urandom};
          br_beat = 0; br_phase = 1; req_ready = 0;
          rsp_valid = ($urandom_range(0, 3) != 0);
          rsp_data = beat_data[br_idx][0]; rsp_last = (br_n == 1); rsp_err = plan_err[br_idx];
        end else begin
          req_ready = ($urandom_range(0, 3) != 0);
        end
      end else if (rsp_hs || !rsp_valid) begin
        if (rsp_hs) br_beat++;
        if (br_beat == br_n) begin
          br_phase = 0; rsp_valid = 0; rsp_last = 0; rsp_err = 0;
          req_ready = ($urandom_range(0, 3) != 0);
        end else begin
          rsp_valid = ($urandom_range(0, 3) != 0);
          rsp_data = beat_data[br_idx][br_beat]; rsp_last = (br_beat == br_n - 1);
          rsp_err = plan_err[br_idx];
        end
      end
    end
  end

  task automatic prep();
    req_log.delete(); got_row.delete(); got_id.delete(); got_last.delete();
    done_cnt = 0; viol = 0;
    for (int k = 0; k < MAXR; k++) begin plan_beats[k] = 4; plan_err[k] = 0; end
  endtask

  task automatic start_run(input logic [31:0] first, input logic [31:0] cnt);
    @(posedge clk); #1;
    first_row_id = first; row_count = cnt; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  // Expected results from the run rules: first NUM_COLS beats, zero-filled, stop at an error row
  task automatic build_model(input logic [31:0] first, input int cnt);
    logic [255:0] r;
    exp_row.delete(); exp_id.delete(); exp_last.delete(); exp_req.delete();
    exp_err = 0; exp_col = 0;
    for (int k = 0; k < cnt; k++) begin
      exp_req.push_back(first + 32'(k));
      if (plan_err[k]) begin exp_err = 1; break; end
      r = '0;
      for (int c = 0; c < 4; c++) if (c < plan_beats[k]) r[c*64 +: 64] = beat_data[k][c];
      if (plan_beats[k] != 4) exp_col = 1;
      exp_row.push_back(r); exp_id.push_back(first + 32'(k)); exp_last.push_back(k == cnt - 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, err, col_err, req_valid, rsp_ready, out_valid, out_last} !== 8'h00 ||
        out_row !== '0 || out_row_id !== '0 || req_row_id !== '0)
      $display("FAIL reset_outputs: flags=%b row_id=%h req_id=%h, required all zero",
               {busy, done, err, col_err, req_valid, rsp_ready, out_valid, out_last},
               out_row_id, req_row_id);
    else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    prep(); cons_mode = 1;
    start_run(32'd5, 32'd3);
    @(negedge clk);
    checks++;
    if (!(req_valid && busy)) $display("FAIL basic_req_first: req_valid=%b busy=%b, required 1 1",
                                       req_valid, busy);
    else passed++;
    wait_done(2000, ok);
    build_model(32'd5, 3);
    checks++; if (!ok) $display("FAIL basic_done: no done within budget, required one"); else passed++;
    checks++;
    if (got_id.size() != exp_id.size())
      $display("FAIL basic_rows: got %0d rows, required %0d", got_id.size(), exp_id.size());
    else passed++;
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      checks++;
      if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i])
        $display("FAIL basic_row%0d: got id=%h last=%b row=%h, required id=%h last=%b row=%h",
                 i, got_id[i], got_last[i], got_row[i], exp_id[i], exp_last[i], exp_row[i]);
      else passed++;
    end
    checks++;
    if ({err, col_err} !== 2'b00 || done_cnt != 1 || viol != 0)
      $display("FAIL basic_flags: err=%b col_err=%b done_cnt=%0d viol=%0d, required 0 0 1 0",
               err, col_err, done_cnt, viol);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok, same;
    prep(); cons_mode = 0;
    start_run(32'd40, 32'd8);
    repeat (80) @(negedge clk);
    checks++;
    if (req_log.size() != 4 || req_valid !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_credit: reqs=%0d req_valid=%b out_valid=%b, required 4 0 1",
               req_log.size(), req_valid, out_valid);
    else passed++;
    start_run(32'd100, 32'd3);  // must be ignored while busy
    cons_mode = 2;
    wait_done(3000, ok);
    build_model(32'd40, 8);
    checks++; if (!ok) $display("FAIL bp_done: no done within budget, required one"); else passed++;
    same = (req_log.size() == exp_req.size());
    for (int i = 0; same && i < req_log.size(); i++) if (req_log[i] !== exp_req[i]) same = 0;
    checks++;
    if (!same) $display("FAIL bp_reqs: got %0d requests, required %0d in order",
                        req_log.size(), exp_req.size());
    else passed++;
    checks++;
    if (got_id.size() != exp_id.size())
      $display("FAIL bp_rows: got %0d rows, required %0d", got_id.size(), exp_id.size());
    else passed++;
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      checks++;
      if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i])
        $display("FAIL bp_row%0d: got id=%h last=%b, required id=%h last=%b",
                 i, got_id[i], got_last[i], exp_id[i], exp_last[i]);
      else passed++;
    end
    checks++;
    if (done_cnt != 1 || viol != 0)
      $display("FAIL bp_proto: done_cnt=%0d viol=%0d, required 1 0", done_cnt, viol);
    else passed++;
  endtask

  task automatic test_rsp_err();
    bit ok, same;
    prep(); cons_mode = 1; plan_err[2] = 1;
    start_run(32'd0, 32'd5);
    wait_done(2000, ok);
    repeat (20) @(negedge clk);
    build_model(32'd0, 5);
    checks++; if (!ok) $display("FAIL err_done: no done within budget, required one"); else passed++;
    same = (req_log.size() == exp_req.size());
    for (int i = 0; same && i < req_log.size(); i++) if (req_log[i] !== exp_req[i]) same = 0;
    checks++;
    if (!same) $display("FAIL err_reqs: got %0d requests, required %0d", req_log.size(),
                        exp_req.size());
    else passed++;
    checks++;
    if (got_id.size() != 2) $display("FAIL err_rows: got %0d rows, required 2", got_id.size());
    else passed++;
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      checks++;
      if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== 1'b0)
        $display("FAIL err_row%0d: got id=%h last=%b, required id=%h last=0",
                 i, got_id[i], got_last[i], exp_id[i]);
      else passed++;
    end
    checks++;
    if (err !== 1'b1 || col_err !== 1'b0 || done_cnt != 1 || viol != 0)
      $display("FAIL err_flags: err=%b col_err=%b done_cnt=%0d viol=%0d, required 1 0 1 0",
               err, col_err, done_cnt, viol);
    else passed++;
  endtask

  task automatic test_col_err();
    bit ok;
    prep(); cons_mode = 2; plan_beats[0] = 2; plan_beats[1] = 6;
    start_run(32'd10, 32'd3);
    wait_done(2000, ok);
    build_model(32'd10, 3);
    checks++; if (!ok) $display("FAIL col_done: no done within budget, required one"); else passed++;
    checks++;
    if (got_id.size() != 3) $display("FAIL col_rows: got %0d rows, required 3", got_id.size());
    else passed++;
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      checks++;
      if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i])
        $display("FAIL col_row%0d: got row=%h, required row=%h", i, got_row[i], exp_row[i]);
      else passed++;
    end
    checks++;
    if (col_err !== 1'b1 || err !== 1'b0 || viol != 0)
      $display("FAIL col_flags: col_err=%b err=%b viol=%0d, required 1 0 0", col_err, err, viol);
    else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    prep(); cons_mode = 1;
    start_run(32'hFFFF_FFFF, 32'd2);
    wait_done(2000, ok);
    checks++;
    if (!ok || req_log.size() != 2) $display("FAIL wrap_reqs: done=%b reqs=%0d, required 1 2",
                                             ok, req_log.size());
    else passed++;
    if (req_log.size() == 2) begin
      checks++;
      if (req_log[0] !== 32'hFFFF_FFFF || req_log[1] !== 32'h0000_0000)
        $display("FAIL wrap_ids: got %h %h, required ffffffff 00000000", req_log[0], req_log[1]);
      else passed++;
    end
    checks++;
    if (got_id.size() != 2 || col_err !== 1'b0)
      $display("FAIL wrap_rows: rows=%0d col_err=%b, required 2 0 (col_err cleared by start)",
               got_id.size(), col_err);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    prep(); cons_mode = 0;
    start_run(32'd20, 32'd6);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_log.size() >= 3 && rsp_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok || out_valid !== 1'b1) $display("FAIL rst_setup: reached=%b out_valid=%b, required 1 1",
                                            ok, out_valid);
    else passed++;
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, done, err, col_err, req_valid, rsp_ready, out_valid, out_last} !== 8'h00 ||
        out_row !== '0 || out_row_id !== '0 || req_row_id !== '0)
      $display("FAIL rst_midrun_outputs: flags=%b row_id=%h, required all zero",
               {busy, done, err, col_err, req_valid, rsp_ready, out_valid, out_last}, out_row_id);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (done_cnt != 0) $display("FAIL rst_no_done: done_cnt=%0d, required 0", done_cnt);
    else passed++;
    prep(); cons_mode = 1;
    start_run(32'd30, 32'd2);
    wait_done(2000, ok);
    build_model(32'd30, 2);
    checks++;
    if (!ok || got_id.size() != 2 || done_cnt != 1 || viol != 0)
      $display("FAIL rst_fresh_run: done=%b rows=%0d done_cnt=%0d viol=%0d, required 1 2 1 0",
               ok, got_id.size(), done_cnt, viol);
    else passed++;
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      checks++;
      if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i])
        $display("FAIL rst_fresh_row%0d: got id=%h last=%b, required id=%h last=%b",
                 i, got_id[i], got_last[i], exp_id[i], exp_last[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_count();
    logic d0;
    prep(); cons_mode = 1;
    @(posedge clk); #1;
    first_row_id = 32'd7; row_count = 32'd0; start = 1;
    @(negedge clk); d0 = done;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (d0 !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0)
      $display("FAIL zero_done: before=%b done=%b busy=%b req_valid=%b, required 0 1 0 0",
               d0, done, busy, req_valid);
    else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (req_log.size() != 0 || done_cnt != 1)
      $display("FAIL zero_quiet: reqs=%0d done_cnt=%0d, required 0 1", req_log.size(), done_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cnt;
    logic [31:0] first;
    for (int run = 0; run < 5; run++) begin
      prep(); cons_mode = $urandom_range(1, 2);
      cnt = $urandom_range(1, 10); first = $urandom;
      for (int k = 0; k < cnt; k++) plan_beats[k] = ($urandom_range(0, 1) != 0) ? 4 :
                                                    $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) plan_err[$urandom_range(0, cnt - 1)] = 1;
      start_run(first, 32'(cnt));
      wait_done(3000, ok);
      build_model(first, cnt);
      checks++;
      if (!ok || got_id.size() != exp_id.size() || done_cnt != 1 || viol != 0)
        $display("FAIL b2b_run%0d: done=%b rows=%0d/%0d done_cnt=%0d viol=%0d", run, ok,
                 got_id.size(), exp_id.size(), done_cnt, viol);
      else passed++;
      for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
        checks++;
        if (got_row[i] !== exp_row[i] || got_id[i] !== exp_id[i] || got_last[i] !== exp_last[i])
          $display("FAIL b2b_run%0d_row%0d: got id=%h last=%b, required id=%h last=%b",
                   run, i, got_id[i], got_last[i], exp_id[i], exp_last[i]);
        else passed++;
      end
      checks++;
      if (err !== exp_err || col_err !== exp_col)
        $display("FAIL b2b_run%0d_flags: err=%b col_err=%b, required %b %b",
                 run, err, col_err, exp_err, exp_col);
      else passed++;
    end
  endtask

  initial begin
    rst = 1; start = 0; first_row_id = '0; row_count = '0; cons_mode = 1;
    prep();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_rsp_err();
    test_col_err();
    test_wrap();
    test_reset_midrun();
    test_zero_count();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sqlite_row_player.md
Name: sqlite_row_player

Overview:
- Hardware-side reader for rows held in the SQLite store; the counterpart of the DPI row-insert path.
- Issues sequential row-fetch requests to a DPI bridge, which services them with sqlite_dpi_get_row / sqlite_dpi_get_cell_value.
- Collects the returned column beats into whole rows, buffers them, and streams them to the DUT or stimulus logic over valid/ready.
- Used to replay recorded tables into simulation.

Parameters:
DATA_W, 64, width of one column value (SQLITE_INTEGER/FLOAT payload)
NUM_COLS, 4, columns per row delivered on out_row
ROW_ID_W, 32, row id width (matches DPI int)
DEPTH, 4, row buffer depth in rows (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  pulse: begin replay run
first_row_id  in  ROW_ID_W  first row id of run, sampled on start
row_count  in  ROW_ID_W  rows to fetch, sampled on start
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
err  out  1  sticky: run aborted by rsp_err; cleared on next accepted start
col_err  out  1  sticky: column-count mismatch seen; cleared on next accepted start
req_valid  out  1  fetch request valid
req_ready  in  1  bridge accepts request
req_row_id  out  ROW_ID_W  row id requested
rsp_valid  in  1  column beat valid
rsp_ready  out  1  block accepts beat
rsp_data  in  DATA_W  column value
rsp_last  in  1  final beat of row
rsp_err  in  1  row missing or DPI failure (beat data ignored)
out_valid  out  1  buffered row available
out_ready  in  1  consumer accepts row
out_row  out  NUM_COLS*DATA_W  row; column 0 in LSBs
out_row_id  out  ROW_ID_W  id of out_row
out_last  out  1  out_row is final row of run

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; err and col_err cleared. Reset mid-run discards all state; no done pulse.
- FSM states: IDLE, REQ, COLLECT, DRAIN.
- IDLE:
  - start with row_count==0 -> done pulse next cycle; stay IDLE.
  - Otherwise latch id and remaining count, clear err/col_err, go to REQ; busy=1 from the next cycle.
  - start while busy is ignored.
- REQ:
  - req_valid=1 only while (fifo_count + 1) <= DEPTH, i.e. a free slot is reserved; at most one request is outstanding.
  - req_row_id is held stable until req_valid && req_ready.
  - On handshake -> COLLECT; req_valid is first asserted the cycle after start.
- COLLECT:
  - rsp_ready=1; beats are written to column index 0..NUM_COLS-1.
  - Beats beyond NUM_COLS are dropped and set col_err.
  - rsp_last before NUM_COLS beats zero-fills the remaining columns and sets col_err.
  - On the rsp_last beat, the row plus its id and last flag are pushed to the FIFO, row id increments (mod 2^ROW_ID_W), and remaining decrements; go to REQ if remaining>0, else DRAIN.
  - A beat with rsp_err: no push, err=1, go to DRAIN.
- DRAIN: wait for FIFO empty, then pulse done and go to IDLE (busy=0 in the same cycle as done).
- FIFO:
  - out_valid = !empty; out_row, out_row_id and out_last are held stable while out_valid && !out_ready.
  - Push and pop in the same cycle are both honoured.
  - The credit rule guarantees no push while full.
  - out_last=1 only on the row whose remaining decremented to 0; never set on an err abort.
- Throughput: one row per NUM_COLS+1 cycles minimum, with zero-wait bridge and consumer.

Test Plan:
- first_row_id=5, row_count=3, bridge returns 4 beats/row, out_ready=1 -> rows id 5,6,7 emitted in order; out_last only on id 7; done pulses once after the last pop; err=col_err=0.
- out_ready=0 with row_count=8, DEPTH=4 -> exactly 4 requests issued, then req_valid stays 0; releasing out_ready resumes fetching; all 8 rows are delivered with none lost.
- Row 2 replies with a single rsp_err beat (row_count=5) -> rows 0,1 delivered; no further req; err=1; done after FIFO drains; no out_last.
- Short row (2 beats, last on 2nd) and long row (6 beats) -> short row columns 2,3 = 0; long row keeps beats 0..3; col_err=1.
- first_row_id=0xFFFFFFFF, row_count=2 -> req ids 0xFFFFFFFF then 0x00000000.
- Assert rst while in COLLECT with 2 rows buffered -> all outputs 0 immediately; a fresh start afterwards runs cleanly; row_count=0 start -> done the next cycle with no req.
